// File: rtl/fwd_regfile.sv
// Parametrised general register file with EX/MEM/WB operand forwarding,
// load-use stall detection and a saturating forwarding-event counter.
module fwd_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NRD-1:0]           re,
  input  logic [NRD*ADDR_W-1:0]    raddr,
  output logic [NRD*DATA_W-1:0]    rdata,
  input  logic                     ex_wreg,
  input  logic [ADDR_W-1:0]        ex_wd,
  input  logic [DATA_W-1:0]        ex_wdata,
  input  logic                     ex_is_load,
  input  logic                     mem_wreg,
  input  logic [ADDR_W-1:0]        mem_wd,
  input  logic [DATA_W-1:0]        mem_wdata,
  output logic                     stallreq,
  output logic [15:0]              fwd_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [NRD-1:0]    fwd_hit;
  logic [NRD-1:0]    hazard;
  logic [ADDR_W-1:0] ra;
  logic              zero_rd;
  logic [SUM_W-1:0]  fwd_sum;

  // Per-port read mux: youngest producer wins, register 0 never forwards.
  always_comb begin
    rdata   = '0;
    fwd_hit = '0;
    hazard  = '0;
    ra      = '0;
    zero_rd = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra      = raddr[i*ADDR_W +: ADDR_W];
      zero_rd = (ZERO_REG != 0) && (ra == '0);
      if (re[i] && !zero_rd && !rst) begin
        hazard[i] = ex_wreg && ex_is_load && (ex_wd == ra);
        if (ex_wreg && (ex_wd == ra) && !ex_is_load) begin
          rdata[i*DATA_W +: DATA_W] = ex_wdata;
          fwd_hit[i]                = 1'b1;
        end else if (mem_wreg && (mem_wd == ra)) begin
          rdata[i*DATA_W +: DATA_W] = mem_wdata;
          fwd_hit[i]                = 1'b1;
        end else if (we && (waddr == ra)) begin
          rdata[i*DATA_W +: DATA_W] = wdata;
        end else begin
          rdata[i*DATA_W +: DATA_W] = regs[ra];
        end
      end
    end
  end

  assign stallreq = |hazard;

  // Counter increment; one spare bit flags overflow for saturation.
  always_comb begin
    fwd_sum = {1'b0, fwd_cnt};
    for (int unsigned i = 0; i < NRD; i++) begin
      fwd_sum = fwd_sum + SUM_W'(fwd_hit[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned d = 0; d < DEPTH; d++) begin
        regs[ADDR_W'(d)] <= '0;
      end
      fwd_cnt <= '0;
    end else begin
      if (we && !((ZERO_REG != 0) && (waddr == '0))) begin
        regs[waddr] <= wdata;
      end
      fwd_cnt <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_fwd_regfile.sv
// Self-checking bench for fwd_regfile (NRD=4) against a rule-level reference model.
module tb_fwd_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NP = 4;

  logic            clk;
  logic            rst;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [NP-1:0]   re;
  logic [NP*AW-1:0] raddr;
  logic [NP*DW-1:0] rdata;
  logic            ex_wreg;
  logic [AW-1:0]   ex_wd;
  logic [DW-1:0]   ex_wdata;
  logic            ex_is_load;
  logic            mem_wreg;
  logic [AW-1:0]   mem_wd;
  logic [DW-1:0]   mem_wdata;
  logic            stallreq;
  logic [15:0]     fwd_cnt;

  int n_cmp;
  int n_fail;

  logic [DW-1:0] m_regs [32];
  int            m_cnt;

  fwd_regfile #(.DATA_W(DW), .ADDR_W(AW), .NRD(NP), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata),
    .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .stallreq(stallreq), .fwd_cnt(fwd_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [AW-1:0] port_addr(int p);
    return raddr[p*AW +: AW];
  endfunction

  // Reference read value for one port, following the ordered read rules.
  function automatic logic [DW-1:0] ref_port(int p);
    logic [AW-1:0] a;
    a = port_addr(p);
    if (rst || !re[p] || a == 0) return '0;
    if (ex_wreg && ex_wd == a && !ex_is_load) return ex_wdata;
    if (mem_wreg && mem_wd == a) return mem_wdata;
    if (we && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic logic [NP*DW-1:0] exp_rdata();
    logic [NP*DW-1:0] r;
    r = '0;
    for (int p = 0; p < NP; p++) r[p*DW +: DW] = ref_port(p);
    return r;
  endfunction

  function automatic logic exp_stall();
    logic s;
    s = 1'b0;
    for (int p = 0; p < NP; p++)
      if (!rst && re[p] && port_addr(p) != 0 && ex_wreg && ex_is_load && ex_wd == port_addr(p))
        s = 1'b1;
    return s;
  endfunction

  function automatic int ref_events();
    int n;
    logic [AW-1:0] a;
    n = 0;
    for (int p = 0; p < NP; p++) begin
      a = port_addr(p);
      if (!rst && re[p] && a != 0 &&
          ((ex_wreg && ex_wd == a && !ex_is_load) || (mem_wreg && mem_wd == a)))
        n++;
    end
    return n;
  endfunction

  // Advance the model by one clock edge, then the DUT; returns #1 after the edge.
  task automatic step();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + ref_events();
      if (m_cnt > 65535) m_cnt = 65535;
      if (we && waddr != 0) m_regs[waddr] = wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    ex_wreg = 1'b0; ex_wd = '0; ex_wdata = '0; ex_is_load = 1'b0;
    mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0;
  endtask

  task automatic set_ra(int p, logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = $urandom;
    re = '1;
    for (int p = 0; p < NP; p++) set_ra(p, 5'd9);
    ex_wreg = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd9;
    #1;
    n_cmp++;
    if (rdata !== '0) begin n_fail++; $display("FAIL reset_gate_rdata got=%h want=0", rdata); end
    n_cmp++;
    if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_gate_stall got=%b want=0", stallreq); end
    step();
    idle();
    #1;
    n_cmp++;
    if (fwd_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got=%h want=0", fwd_cnt); end
    for (int g = 0; g < 8; g++) begin
      re = '1;
      for (int p = 0; p < NP; p++) set_ra(p, AW'(g*4 + p));
      #1;
      n_cmp++;
      if (rdata !== '0) begin n_fail++; $display("FAIL reset_read g=%0d got=%h want=0", g, rdata); end
      n_cmp++;
      if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stall g=%0d got=%b want=0", g, stallreq); end
      step();
    end
  endtask

  task automatic test_write_read();
    idle();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    idle();
    re = 4'b0001; set_ra(0, 5'd5);
    #1;
    n_cmp++;
    if (rdata[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_read_r5 got=%h want=deadbeef", rdata[31:0]); end
    step();
    idle();
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    step();
    idle();
    re = 4'b0001; set_ra(0, 5'd0);
    #1;
    n_cmp++;
    if (rdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL write_r0 got=%h want=0", rdata[31:0]); end
    step();
  endtask

  task automatic test_priority();
    int c0;
    idle();
    we = 1'b1; waddr = 5'd7; wdata = 32'hA0;
    re = 4'b0001; set_ra(0, 5'd7);
    #1;
    c0 = m_cnt;
    n_cmp++;
    if (rdata[31:0] !== 32'hA0) begin n_fail++; $display("FAIL wb_through got=%h want=a0", rdata[31:0]); end
    step();
    n_cmp++;
    if (fwd_cnt !== 16'(c0)) begin n_fail++; $display("FAIL wb_no_count got=%h want=%h", fwd_cnt, 16'(c0)); end
    mem_wreg = 1'b1; mem_wd = 5'd7; mem_wdata = 32'hB0;
    #1;
    n_cmp++;
    if (rdata[31:0] !== 32'hB0) begin n_fail++; $display("FAIL mem_over_wb got=%h want=b0", rdata[31:0]); end
    step();
    n_cmp++;
    if (fwd_cnt !== 16'(c0 + 1)) begin n_fail++; $display("FAIL mem_count got=%h want=%h", fwd_cnt, 16'(c0 + 1)); end
    ex_wreg = 1'b1; ex_wd = 5'd7; ex_wdata = 32'hC0;
    #1;
    n_cmp++;
    if (rdata[31:0] !== 32'hC0) begin n_fail++; $display("FAIL ex_over_mem got=%h want=c0", rdata[31:0]); end
    step();
    n_cmp++;
    if (fwd_cnt !== 16'(c0 + 2)) begin n_fail++; $display("FAIL ex_count got=%h want=%h", fwd_cnt, 16'(c0 + 2)); end
    idle();
  endtask

  task automatic test_load_use();
    idle();
    ex_wreg = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd9; ex_wdata = 32'hFFFF_0000;
    mem_wreg = 1'b1; mem_wd = 5'd9; mem_wdata = 32'h99;
    set_ra(1, 5'd9); re = 4'b0010;
    #1;
    n_cmp++;
    if (stallreq !== 1'b1) begin n_fail++; $display("FAIL load_use_stall got=%b want=1", stallreq); end
    n_cmp++;
    if (rdata[63:32] !== 32'h99) begin n_fail++; $display("FAIL load_use_data got=%h want=99", rdata[63:32]); end
    re = 4'b0000;
    #1;
    n_cmp++;
    if (stallreq !== 1'b0) begin n_fail++; $display("FAIL load_use_re0 got=%b want=0", stallreq); end
    re = 4'b0010; ex_wd = 5'd0; set_ra(1, 5'd0);
    #1;
    n_cmp++;
    if (stallreq !== 1'b0) begin n_fail++; $display("FAIL load_use_r0 got=%b want=0", stallreq); end
    step();
    idle();
  endtask

  task automatic test_multiport();
    logic [DW-1:0] v12;
    int c0;
    idle();
    v12 = $urandom;
    we = 1'b1; waddr = 5'd12; wdata = v12;
    step();
    idle();
    re = 4'b1111;
    set_ra(0, 5'd3); set_ra(1, 5'd3); set_ra(2, 5'd0); set_ra(3, 5'd12);
    mem_wreg = 1'b1; mem_wd = 5'd3; mem_wdata = 32'h55;
    #1;
    c0 = m_cnt;
    n_cmp++;
    if (rdata !== {v12, 32'h0, 32'h55, 32'h55}) begin
      n_fail++; $display("FAIL multiport got=%h want=%h", rdata, {v12, 32'h0, 32'h55, 32'h55});
    end
    step();
    n_cmp++;
    if (fwd_cnt !== 16'(c0 + 2)) begin n_fail++; $display("FAIL multiport_cnt got=%h want=%h", fwd_cnt, 16'(c0 + 2)); end
    idle();
  endtask

  task automatic test_random();
    logic [NP*DW-1:0] er;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      we = $urandom_range(0, 1) == 1;
      waddr = AW'($urandom_range(0, 7));
      wdata = $urandom;
      re = NP'($urandom);
      for (int p = 0; p < NP; p++) set_ra(p, AW'($urandom_range(0, 7)));
      ex_wreg = $urandom_range(0, 1) == 1;
      ex_wd = AW'($urandom_range(0, 7));
      ex_wdata = $urandom;
      ex_is_load = $urandom_range(0, 3) == 0;
      mem_wreg = $urandom_range(0, 1) == 1;
      mem_wd = AW'($urandom_range(0, 7));
      mem_wdata = $urandom;
      #1;
      er = exp_rdata();
      n_cmp++;
      if (rdata !== er) begin n_fail++; $display("FAIL rand_rdata k=%0d got=%h want=%h", k, rdata, er); end
      n_cmp++;
      if (stallreq !== exp_stall()) begin n_fail++; $display("FAIL rand_stall k=%0d got=%b want=%b", k, stallreq, exp_stall()); end
      n_cmp++;
      if (fwd_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt k=%0d got=%h want=%h", k, fwd_cnt, 16'(m_cnt)); end
      step();
    end
    idle();
  endtask

  task automatic test_saturation();
    int bad;
    idle();
    bad = 0;
    re = 4'b1111;
    for (int p = 0; p < NP; p++) set_ra(p, 5'd3);
    mem_wreg = 1'b1; mem_wd = 5'd3; mem_wdata = 32'h77;
    for (int k = 0; k < 16400; k++) begin
      step();
      if (fwd_cnt !== 16'(m_cnt) && bad < 5) begin
        bad++;
        $display("FAIL sat_track k=%0d got=%h want=%h", k, fwd_cnt, 16'(m_cnt));
      end
    end
    n_cmp++;
    if (bad != 0) n_fail++;
    n_cmp++;
    if (fwd_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_limit got=%h want=ffff", fwd_cnt); end
    step();
    step();
    n_cmp++;
    if (fwd_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h want=ffff", fwd_cnt); end
    idle();
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] v;
    idle();
    v = $urandom | 32'h1;
    we = 1'b1; waddr = 5'd4; wdata = v;
    step();
    idle();
    re = 4'b0001; set_ra(0, 5'd4);
    #1;
    n_cmp++;
    if (rdata[31:0] !== v) begin n_fail++; $display("FAIL mid_pre got=%h want=%h", rdata[31:0], v); end
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = ~v;
    step();
    idle();
    re = 4'b0001; set_ra(0, 5'd4);
    #1;
    n_cmp++;
    if (rdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL mid_r4 got=%h want=0", rdata[31:0]); end
    n_cmp++;
    if (fwd_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_cnt got=%h want=0", fwd_cnt); end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    m_cnt = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    idle();
    test_reset();
    test_write_read();
    test_priority();
    test_load_use();
    test_multiport();
    test_random();
    test_saturation();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
